// File: rtl/slicem_lutram.sv
// SLICEM-style LUT/RAM/SRL block: NUM_LUTS dual-half LUTs sharing one serial config chain.
// Optional macro SLICEM_SRL_EN enables shift-register mode (mode 10); without it mode 10 reads as a LUT.

module slicem_lut_rd #(
    parameter int INPUTS = 4
) (
    input  logic [2*(2**INPUTS)-1:0] bits,
    input  logic [INPUTS-1:0]        addr,
    output logic [1:0]               q
);
    assign q[0] = bits[{1'b0, addr}];
    assign q[1] = bits[{1'b1, addr}];
endmodule

module slicem_lutram #(
    parameter  int INPUTS   = 4,
    parameter  int NUM_LUTS = 4,
    localparam int MUX_LVLS = $clog2(NUM_LUTS),
    localparam int AW       = MUX_LVLS + 1 + INPUTS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_LUTS*INPUTS-1:0]   luts_in,
    input  logic                         cfg_in,
    input  logic                         cfg_en,
    input  logic                         cfg_start,
    output logic                         cfg_done,
    input  logic                         write_en,
    input  logic [AW-1:0]                waddr,
    input  logic                         data_in,
    input  logic                         shift_en,
    input  logic                         reg_ce,
    output logic [2*NUM_LUTS-1:0]        out,
    output logic [2*NUM_LUTS-1:0]        sync_out,
    output logic                         srl_out
);
    localparam int LUT_BITS = 2**(INPUTS+1);
    localparam int MEM_BITS = NUM_LUTS*LUT_BITS;
    localparam int CFG_LEN  = MEM_BITS + 2;
    localparam int CW       = $clog2(CFG_LEN+1);
    localparam logic [CW-1:0] CFG_LEN_C = CW'(CFG_LEN);
    localparam logic [1:0] MODE_RAM = 2'b01;
    localparam logic [1:0] MODE_SRL = 2'b10;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic          data;
    } wr_req_t;

    logic [1:0]          mode;
    logic [MEM_BITS-1:0] mem;
    logic [CW-1:0]       cfg_cnt;
    wr_req_t             wr;
    logic                srl_shift;

    // Config shifting always wins; write and shift only apply in their own mode.
    assign wr.en   = write_en && !cfg_en && (mode == MODE_RAM);
    assign wr.addr = waddr;
    assign wr.data = data_in;

`ifdef SLICEM_SRL_EN
    assign srl_shift = shift_en && !cfg_en && (mode == MODE_SRL);
`else
    logic unused_shift_en;
    assign unused_shift_en = shift_en;
    assign srl_shift       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 2'b00;
            mem  <= '0;
        end else if (cfg_en) begin
            {mode, mem} <= {mode[0], mem, cfg_in};
        end else if (wr.en) begin
            mem[wr.addr] <= wr.data;
        end else if (srl_shift) begin
            mem <= {mem[MEM_BITS-2:0], data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg_cnt <= '0;
        else if (cfg_start)
            cfg_cnt <= {{(CW-1){1'b0}}, cfg_en};
        else if (cfg_en && cfg_cnt != CFG_LEN_C)
            cfg_cnt <= cfg_cnt + 1'b1;
    end

    assign cfg_done = (cfg_cnt == CFG_LEN_C);
    assign srl_out  = mem[MEM_BITS-1];

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        slicem_lut_rd #(.INPUTS(INPUTS)) u_rd (
            .bits (mem[i*LUT_BITS +: LUT_BITS]),
            .addr (luts_in[i*INPUTS +: INPUTS]),
            .q    (out[2*i +: 2])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_out <= '0;
        else if (reg_ce)
            sync_out <= out;
    end
endmodule

// File: tb/tb_slicem_lutram.sv
// Randomized bench for slicem_lutram against a bit-array reference model, plus directed literal checks.
`timescale 1ns/1ps
module tb_slicem_lutram;
    localparam int INPUTS   = 4;
    localparam int NUM_LUTS = 4;
    localparam int AW       = $clog2(NUM_LUTS) + 1 + INPUTS;
    localparam int HALF     = 2**INPUTS;
    localparam int MEM_BITS = NUM_LUTS*2*HALF;
    localparam int CFG_LEN  = MEM_BITS + 2;
    localparam int NO       = 2*NUM_LUTS;
`ifdef SLICEM_SRL_EN
    localparam bit SRL = 1'b1;
`else
    localparam bit SRL = 1'b0;
`endif

    logic clk = 0, rst_n = 0;
    logic [NUM_LUTS*INPUTS-1:0] luts_in = '0;
    logic cfg_in = 0, cfg_en = 0, cfg_start = 0, write_en = 0, data_in = 0, shift_en = 0, reg_ce = 0;
    logic [AW-1:0] waddr = '0;
    logic cfg_done, srl_out;
    logic [NO-1:0] out, sync_out;

    int n_cmp = 0, n_fail = 0;

    slicem_lutram #(.INPUTS(INPUTS), .NUM_LUTS(NUM_LUTS)) dut (
        .clk(clk), .rst_n(rst_n), .luts_in(luts_in), .cfg_in(cfg_in), .cfg_en(cfg_en),
        .cfg_start(cfg_start), .cfg_done(cfg_done), .write_en(write_en), .waddr(waddr),
        .data_in(data_in), .shift_en(shift_en), .reg_ce(reg_ce), .out(out),
        .sync_out(sync_out), .srl_out(srl_out)
    );

    always #5 clk = ~clk;

    // Reference model: mode number, flat bit array, integer counter.
    int            m_mode;
    bit            m_mem [MEM_BITS];
    int            m_cnt;
    logic [NO-1:0] m_sync;

    function automatic logic [NO-1:0] model_out(logic [NUM_LUTS*INPUTS-1:0] a);
        logic [NO-1:0] r;
        for (int i = 0; i < NUM_LUTS; i++)
            for (int h = 0; h < 2; h++)
                r[2*i+h] = m_mem[i*2*HALF + h*HALF + int'(a[i*INPUTS +: INPUTS])];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_sync = '0;
            for (int k = 0; k < MEM_BITS; k++) m_mem[k] = 0;
        end else begin
            if (reg_ce) m_sync = model_out(luts_in);
            if (cfg_en) begin
                // Chain order is mode[1], mode[0], mem[MEM_BITS-1] ... mem[0].
                m_mode = ((m_mode % 2) * 2) + int'(m_mem[MEM_BITS-1]);
                for (int k = MEM_BITS-1; k > 0; k--) m_mem[k] = m_mem[k-1];
                m_mem[0] = cfg_in;
            end else if (m_mode == 1 && write_en) begin
                m_mem[int'(waddr)] = data_in;
            end else if (SRL && m_mode == 2 && shift_en) begin
                for (int k = MEM_BITS-1; k > 0; k--) m_mem[k] = m_mem[k-1];
                m_mem[0] = data_in;
            end
            if (cfg_start) m_cnt = cfg_en ? 1 : 0;
            else if (cfg_en && m_cnt < CFG_LEN) m_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("out", 64'(out), 64'(model_out(luts_in)));
        chk("sync_out", 64'(sync_out), 64'(m_sync));
        chk("srl_out", 64'(srl_out), 64'(m_mem[MEM_BITS-1]));
        chk("cfg_done", 64'(cfg_done), 64'(m_cnt == CFG_LEN));
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Shifts v in MSB first so the chain ends up holding {mode, mem} = v.
    task automatic load(input logic [CFG_LEN-1:0] v);
        for (int k = CFG_LEN-1; k >= 0; k--) begin
            cfg_en = 1; cfg_in = v[k]; cfg_start = (k == CFG_LEN-1);
            step();
            if (k == 1) chk("done_after_129", 64'(cfg_done), 64'd0);
        end
        cfg_en = 0; cfg_start = 0;
        chk("done_after_130", 64'(cfg_done), 64'd1);
    endtask

    logic [CFG_LEN-1:0] v;

    initial begin
        #12;
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_done", 64'(cfg_done), 64'd0);
        step(); step();
        rst_n = 1;
        step();

        // Full load into RAM mode with all ones.
        reg_ce = 1;
        load({2'b01, {MEM_BITS{1'b1}}});
        for (int j = 0; j < 4; j++) begin
            luts_in = NUM_LUTS*INPUTS'($urandom);
            #1 chk("load_all_ones", 64'(out), 64'hFF);
        end
        luts_in = 16'h0500;
        step();
        chk("sync_ff", 64'(sync_out), 64'hFF);

        // RAM write of a zero to LUT 2 half 1 bit 5, with sync_out gated off.
        reg_ce = 0; write_en = 1; waddr = {2'd2, 1'b1, 4'd5}; data_in = 0;
        #1 chk("ram_old_before_edge", 64'(out[5]), 64'd1);
        step();
        write_en = 0;
        chk("ram_new_bit", 64'(out[5]), 64'd0);
        chk("ram_neighbour", 64'(out[4]), 64'd1);
        chk("sync_hold", 64'(sync_out), 64'hFF);
        step();
        chk("sync_hold2", 64'(sync_out), 64'hFF);
        reg_ce = 1;
        step();
        chk("sync_update", 64'(sync_out), 64'hDF);

        // Write together with config shift: the shift wins and the counter restarts from zero.
        cfg_start = 1; step(); cfg_start = 0;
        luts_in = '0; cfg_en = 1; cfg_in = 0; write_en = 1; waddr = '0; data_in = 1;
        step();
        cfg_en = 0; write_en = 0;
        chk("prio_shift_wins", 64'(out[0]), 64'd0);
        chk("prio_cnt_one", 64'(cfg_done), 64'd0);

        // Asynchronous reset asserted mid-cycle.
        #4 rst_n = 0;
        #1;
        chk("async_out", 64'(out), 64'd0);
        chk("async_sync", 64'(sync_out), 64'd0);
        chk("async_srl", 64'(srl_out), 64'd0);
        chk("async_done", 64'(cfg_done), 64'd0);
        step(); rst_n = 1; step();

        // Reset in the middle of a load discards the partial contents.
        for (int k = 0; k < 60; k++) begin
            cfg_en = 1; cfg_in = 1; cfg_start = (k == 0); step();
        end
        cfg_en = 0; cfg_start = 0;
        #4 rst_n = 0;
        #1 chk("partial_discard", 64'(out), 64'd0);
        step(); rst_n = 1; step();

        // SRL cascade from an all-zero memory.
        load({2'b10, {MEM_BITS{1'b0}}});
        luts_in = '0; shift_en = 1; data_in = 1;
        step();
        chk("srl_first", 64'(out[0]), 64'(SRL));
        repeat (126) step();
        chk("srl_not_yet", 64'(srl_out), 64'd0);
        step();
        chk("srl_128", 64'(srl_out), 64'(SRL));
        shift_en = 0; data_in = 0;

        // Randomized blocks, each starting from a random load in a chosen mode.
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < CFG_LEN; k++) v[k] = 1'($urandom);
            v[CFG_LEN-1 -: 2] = 2'(b % 4);
            load(v);
            for (int c = 0; c < 300; c++) begin
                luts_in   = NUM_LUTS*INPUTS'($urandom);
                cfg_en    = ($urandom_range(0, 63) == 0);
                cfg_start = ($urandom_range(0, 99) == 0);
                cfg_in    = 1'($urandom);
                write_en  = 1'($urandom);
                shift_en  = 1'($urandom);
                data_in   = 1'($urandom);
                reg_ce    = 1'($urandom);
                waddr     = AW'($urandom);
                step();
            end
            cfg_en = 0; cfg_start = 0; write_en = 0; shift_en = 0;
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/slicem_lutram.md
SLICEM_LUTRAM -- requirements
Module: slicem_lutram

Interface
REQ-001 Parameter INPUTS, default 4, LUT address width; each LUT half holds 2**INPUTS bits.
REQ-002 Parameter NUM_LUTS, default 4, power of 2; MUX_LVLS = clog2(NUM_LUTS); MEM_BITS = NUM_LUTS*2**(INPUTS+1); CFG_LEN = MEM_BITS+2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 luts_in  input  NUM_LUTS*INPUTS  read address; LUT i uses bits [i*INPUTS +: INPUTS].
REQ-006 cfg_in  input  1  serial configuration bit.
REQ-007 cfg_en  input  1  shift cfg_in into the configuration chain.
REQ-008 cfg_start  input  1  clear the configuration bit counter.
REQ-009 cfg_done  output  1  high once CFG_LEN bits have been shifted since the last cfg_start or reset.
REQ-010 write_en  input  1  single-bit write strobe, RAM mode only.
REQ-011 waddr  input  MUX_LVLS+1+INPUTS  write address {lut_sel, half, bit}.
REQ-012 data_in  input  1  write data in RAM mode; shift data in SRL mode.
REQ-013 shift_en  input  1  SRL shift strobe.
REQ-014 reg_ce  input  1  enable for sync_out.
REQ-015 out  output  2*NUM_LUTS  combinational read; out[2i+h] is LUT i, half h.
REQ-016 sync_out  output  2*NUM_LUTS  registered copy of out.
REQ-017 srl_out  output  1  mem[MEM_BITS-1], the SRL cascade output.

Function
REQ-018 State: mode[1:0] plus mem[MEM_BITS-1:0]; mem index = lut*2**(INPUTS+1) + half*2**INPUTS + addr.
REQ-019 out[2i+h] SHALL equal mem[index(i, h, luts_in[i])] in every mode, with no latency.
REQ-020 Modes: 00 LUT (read-only), 01 RAM, 10 SRL, 11 reserved and treated as LUT.
REQ-021 Config chain: when cfg_en=1, {mode, mem} <= {mode, mem}[CFG_LEN-2:0] concatenated with cfg_in, so the first bit shifted in ends in mode[1].
REQ-022 Config counter: on cfg_start it SHALL clear to 0, then add 1 if cfg_en=1 in the same cycle; otherwise it SHALL increment on cfg_en and saturate at CFG_LEN.
REQ-023 cfg_done = (counter == CFG_LEN); it SHALL rise in the cycle after the CFG_LEN-th shift edge.
REQ-024 RAM mode: write_en=1 and cfg_en=0 SHALL write mem[waddr] <= data_in at the edge; all other bits are unchanged.
REQ-025 SRL mode: shift_en=1 and cfg_en=0 SHALL set mem <= {mem[MEM_BITS-2:0], data_in}, cascading LUT i's MSB into LUT i+1.
REQ-026 Priority: cfg_en over write_en/shift_en, which SHALL then be ignored; write_en SHALL be ignored outside RAM mode, and shift_en outside SRL mode.
REQ-027 A read of an address being written SHALL return the old value until the edge and the new value after it.
REQ-028 sync_out <= out when reg_ce=1; otherwise it holds.
REQ-029 A mode change takes effect on the first cycle after the shift that completes it.

Reset
REQ-030 While rst_n=0: mode=00, mem=0, counter=0, sync_out=0; hence out=0, srl_out=0, cfg_done=0.
REQ-031 Reset mid-configuration SHALL discard partial contents; a full reload is required after reset.

Configuration
REQ-032 Macro SLICEM_SRL_EN defined: SRL mode as in REQ-025.
REQ-033 Macro SLICEM_SRL_EN undefined: mode 10 behaves as LUT, shift_en is ignored, and srl_out still equals mem[MEM_BITS-1].

Verification (defaults: MEM_BITS=128, CFG_LEN=130)
REQ-034 Check reset: assert rst_n=0 asynchronously mid-cycle -> out, sync_out, srl_out and cfg_done are all 0 immediately.
REQ-035 Check configuration load: cfg_start, then 130 cfg_en shifts of bits 0,1 followed by 128 ones -> cfg_done=0 after 129 shifts and 1 after 130; mode=01; out=8'hFF for any luts_in.
REQ-036 Check a RAM write: in RAM mode, write_en with waddr={2'd2,1'b1,4'd5}, data_in=0, and luts_in[2]=5 -> out[5] becomes 0 after the edge while out[4] is unchanged.
REQ-037 Check write/config priority: write_en=1 together with cfg_en=1 -> the write is ignored, the chain shifts, and the counter increments.
REQ-038 Check the SRL cascade: in SRL mode with mem=0, one shift with data_in=1 -> out[0]=1 for luts_in[0]=0; srl_out=1 exactly after 128 such shifts; with SLICEM_SRL_EN undefined, mem is unchanged.
REQ-039 Check sync_out gating: reg_ce=0 while out changes -> sync_out holds; reg_ce=1 -> sync_out equals out one edge later.
